vga_frame_reader: RTL and testbench

Pixel-source stage directly downstream of the VGA timing decoder. On every pixel tick it converts the decoder's (x_pixel, y_pixel, DE) into a 2x-upscaled address into a double-buffered 320x240 RGB565 frame buffer and issues a synchronous read. It outputs 4-bit-per-channel RGB with h_sync, v_sync and DE delayed to match the read latency. It also arbitrates buffer swaps from the frame writer so that a swap only takes effect on a frame boundary.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_frame_reader_if.sv | 27 ++
 rtl/vga_sync_delay.sv | 31 +++
 rtl/vga_frame_reader.sv | 167 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-source path.
//   H_ACTIVE/V_ACTIVE : visible raster size driven by the timing decoder
//   FB_W/FB_H         : frame-buffer size (half resolution, 2x upscaled)
//   BANK_SIZE         : words per frame-buffer bank, also bank 1 base address
//   rgb565_t          : frame-buffer word layout
//   swap_state_t      : buffer-swap arbiter states
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int BANK_SIZE = FB_W * FB_H;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    SHOW    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus writer swap handshake.
//   rd_en/rd_addr : read strobe and word address (reader -> memory)
//   rd_data       : RGB565 word, valid the clk after rd_en (memory -> reader)
//   swap_req      : one-clk request from the writer to flip banks
//   swap_ack      : one-clk acknowledge when the flip is applied
//   disp_bank     : bank currently being displayed
// master = frame reader, slave = memory / frame-writer side.
interface vga_frame_reader_if;

  logic        rd_en;
  logic [17:0] rd_addr;
  logic [15:0] rd_data;
  logic        swap_req;
  logic        swap_ack;
  logic        disp_bank;

  modport master (
    output rd_en, rd_addr, swap_ack, disp_bank,
    input  rd_data, swap_req
  );

  modport slave (
    input  rd_en, rd_addr, swap_ack, disp_bank,
    output rd_data, swap_req
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Two-stage pixel-tick-enabled delay line for {DE, h_sync, v_sync}.
//   clk, reset : system clock, async active-high reset
//   en         : pixel tick; stages only advance when high
//   d          : {DE, h_sync, v_sync} from the timing decoder
//   q_p0       : stage A copy (one tick old)
//   q_p1       : stage B copy (two ticks old), drives the outputs
// Reset value {0,1,1}: video disabled, both syncs idle (active-low).
module vga_sync_delay (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q_p0,
  output logic [2:0] q_p1
);

  localparam logic [2:0] IDLE = 3'b011;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_p0 <= IDLE;
      q_p1 <= IDLE;
    end else if (en) begin
      // stage A
      q_p0 <= d;
      // stage B
      q_p1 <= q_p0;
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Pixel source behind the VGA timing decoder. Each pixel tick maps the
// decoder position to a 2x-upscaled address in a double-buffered 320x240
// RGB565 frame buffer, issues one read, and presents RGB444 plus sync/DE
// delayed to line up with the read. Bank swaps requested by the writer are
// deferred to the next v_sync falling edge (vertical blanking).
//   clk, reset               : system clock, async active-high reset
//   pclk                     : one-clk pixel tick enable
//   x_pixel, y_pixel, DE     : decoder position and active-video flag
//   h_sync, v_sync           : decoder syncs (active-low)
//   bus                      : frame-buffer read port and swap handshake
//   red, green, blue         : 4-bit colour outputs
//   h_sync_o, v_sync_o, DE_o : latency-matched sync and enable
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int FB_W      = vga_pkg::FB_W,
  parameter int FB_H      = vga_pkg::FB_H,
  parameter int BANK_SIZE = vga_pkg::BANK_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pclk,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic                  DE,
  input  logic                  h_sync,
  input  logic                  v_sync,
  vga_frame_reader_if.master    bus,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  h_sync_o,
  output logic                  v_sync_o,
  output logic                  DE_o
);

  // Row offset uses (y<<8)+(y<<6) = y*320, so this block assumes FB_W=320.
  function automatic logic [17:0] fb_addr(input logic bank,
                                          input logic [9:0] x,
                                          input logic [9:0] y);
    logic [17:0] row;
    logic [17:0] base;
    row  = 18'(y >> 1);
    base = bank ? 18'(BANK_SIZE) : 18'd0;
    return base + (row << 8) + (row << 6) + 18'(x >> 1);
  endfunction

  // Keep the top nibble of each channel.
  function automatic logic [11:0] to_rgb444(input rgb565_t p);
    return {4'(p.r >> 1), 4'(p.g >> 2), 4'(p.b >> 1)};
  endfunction

  logic [2:0]  sync_p0;
  logic [2:0]  sync_p1;
  logic        de_p0;
  logic        vs_p0;
  logic        rd_vld_p0;
  logic [15:0] hold_p0;
  rgb565_t     pix_p0;
  logic [11:0] rgb_p0;

  swap_state_t state_q;
  swap_state_t state_d;
  logic        ack_d;
  logic        toggle_d;
  logic        vs_fall;

  vga_sync_delay u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .en    (pclk),
    .d     ({DE, h_sync, v_sync}),
    .q_p0  (sync_p0),
    .q_p1  (sync_p1)
  );

  assign de_p0    = sync_p0[2];
  assign vs_p0    = sync_p0[0];
  assign DE_o     = sync_p1[2];
  assign h_sync_o = sync_p1[1];
  assign v_sync_o = sync_p1[0];

  // stage A: issue the frame-buffer read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
    end else begin
      bus.rd_en <= pclk & DE;
      if (pclk && DE)
        bus.rd_addr <= fb_addr(bus.disp_bank, x_pixel, y_pixel);
    end
  end

  // hold stage: capture the returned word, independent of pclk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p0 <= 1'b0;
      hold_p0   <= '0;
    end else begin
      rd_vld_p0 <= bus.rd_en;
      if (rd_vld_p0)
        hold_p0 <= bus.rd_data;
    end
  end

  // At the fastest tick rate (every 2 clks) stage B coincides with the
  // capture edge, so take the word straight from the bus in that case.
  assign pix_p0 = rgb565_t'(rd_vld_p0 ? bus.rd_data : hold_p0);
  assign rgb_p0 = to_rgb444(pix_p0);

  // stage B: colour outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pclk) begin
      if (de_p0) begin
        red   <= rgb_p0[11:8];
        green <= rgb_p0[7:4];
        blue  <= rgb_p0[3:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // v_sync falling edge, judged against the value registered at the previous tick.
  assign vs_fall = pclk & vs_p0 & ~v_sync;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    toggle_d = 1'b0;
    case (state_q)
      SHOW: begin
        // A request on the edge clk itself waits for the next frame.
        if (bus.swap_req)
          state_d = PENDING;
      end
      PENDING: begin
        if (vs_fall) begin
          state_d  = SHOW;
          ack_d    = 1'b1;
          toggle_d = 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SHOW;
      bus.swap_ack  <= 1'b0;
      bus.disp_bank <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.swap_ack  <= ack_d;
      bus.disp_bank <= bus.disp_bank ^ toggle_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pclk = 1'b0;
  logic [9:0] x_pixel = '0;
  logic [9:0] y_pixel = '0;
  logic       DE = 1'b0;
  logic       h_sync = 1'b1;
  logic       v_sync = 1'b1;
  logic [3:0] red, green, blue;
  logic       h_sync_o, v_sync_o, DE_o;

  vga_frame_reader_if fb_if ();

  vga_frame_reader dut (
    .clk      (clk),
    .reset    (reset),
    .pclk     (pclk),
    .x_pixel  (x_pixel),
    .y_pixel  (y_pixel),
    .DE       (DE),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .bus      (fb_if.master),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .h_sync_o (h_sync_o),
    .v_sync_o (v_sync_o),
    .DE_o     (DE_o)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous read returning mem_word the clk after rd_en.
  logic [15:0] mem_word = '0;
  int          rd_cnt = 0;
  int          ack_cnt = 0;
  logic [17:0] last_addr = '0;

  always @(posedge clk) begin
    if (fb_if.rd_en) begin
      fb_if.rd_data <= mem_word;
      rd_cnt        <= rd_cnt + 1;
      last_addr     <= fb_if.rd_addr;
    end
    if (fb_if.swap_ack)
      ack_cnt <= ack_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel tick every 4 clks; inputs and optional swap_req driven on the tick clk.
  task automatic tick(input int x, input int y, input logic de, input logic hs,
                      input logic vs, input logic req = 1'b0);
    @(negedge clk);
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    DE = de;
    h_sync = hs;
    v_sync = vs;
    pclk = 1'b1;
    fb_if.swap_req = req;
    @(negedge clk);
    pclk = 1'b0;
    fb_if.swap_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    fb_if.swap_req = 1'b1;
    @(negedge clk);
    fb_if.swap_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int r0, a0;

  initial begin
    fb_if.swap_req = 1'b0;
    fb_if.rd_data  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_red", red, 0);
    chk("rst_grn", green, 0);
    chk("rst_blu", blue, 0);
    chk("rst_rd_en", fb_if.rd_en, 0);
    chk("rst_rd_addr", fb_if.rd_addr, 0);
    chk("rst_hs_o", h_sync_o, 1);
    chk("rst_vs_o", v_sync_o, 1);
    chk("rst_de_o", DE_o, 0);
    chk("rst_ack", fb_if.swap_ack, 0);
    chk("rst_bank", fb_if.disp_bank, 0);
    reset = 1'b0;

    // First read: x=5,y=3 bank 0 -> 1*320+2 = 322, one rd_en clk
    mem_word = 16'hF800;
    r0 = rd_cnt;
    tick(5, 3, 1, 1, 1);
    chk("rd_once", rd_cnt - r0, 1);
    chk("rd_addr_322", last_addr, 322);
    chk("rd_en_low", fb_if.rd_en, 0);
    tick(5, 3, 1, 1, 1);
    chk("red_F800", red, 4'hF);
    chk("grn_F800", green, 0);
    chk("blu_F800", blue, 0);
    chk("de_o_on", DE_o, 1);

    mem_word = 16'h07E0;
    tick(5, 3, 1, 1, 1);
    tick(5, 3, 1, 1, 1);
    chk("red_07E0", red, 0);
    chk("grn_07E0", green, 4'hF);
    chk("blu_07E0", blue, 0);

    // A5A5: r=10100 g=101101 b=00101 -> A, B, 2
    mem_word = 16'hA5A5;
    tick(5, 3, 1, 1, 1);
    tick(5, 3, 1, 1, 1);
    chk("red_A5A5", red, 4'hA);
    chk("grn_A5A5", green, 4'hB);
    chk("blu_A5A5", blue, 4'h2);

    // Blanking: no read, address held, black, syncs follow
    r0 = rd_cnt;
    tick(700, 100, 0, 0, 1);
    tick(700, 100, 0, 0, 1);
    chk("blank_no_rd", rd_cnt - r0, 0);
    chk("blank_addr_hold", fb_if.rd_addr, 322);
    chk("blank_red", red, 0);
    chk("blank_grn", green, 0);
    chk("blank_blu", blue, 0);
    chk("blank_de_o", DE_o, 0);
    chk("blank_hs_o", h_sync_o, 0);

    // Swap deferred to v_sync falling edge
    a0 = ack_cnt;
    tick(5, 200, 1, 1, 1);
    pulse_req();
    tick(5, 200, 1, 1, 1);
    tick(0, 489, 0, 1, 1);
    chk("swap_wait_bank", fb_if.disp_bank, 0);
    chk("swap_wait_ack", ack_cnt - a0, 0);
    tick(0, 490, 0, 1, 0);
    chk("swap_ack_once", ack_cnt - a0, 1);
    chk("swap_bank1", fb_if.disp_bank, 1);
    tick(0, 491, 0, 1, 0);
    chk("swap_no_more", ack_cnt - a0, 1);
    chk("vs_o_low", v_sync_o, 0);
    tick(5, 3, 1, 1, 1);
    chk("bank1_addr", last_addr, 77122);

    // Two requests in one frame -> one swap
    a0 = ack_cnt;
    pulse_req();
    tick(5, 100, 1, 1, 1);
    pulse_req();
    tick(5, 101, 1, 1, 1);
    tick(0, 490, 0, 1, 0);
    chk("dbl_ack", ack_cnt - a0, 1);
    chk("dbl_bank", fb_if.disp_bank, 0);
    tick(0, 492, 0, 1, 1);
    tick(0, 490, 0, 1, 0);
    chk("dbl_next_ack", ack_cnt - a0, 1);
    chk("dbl_next_bank", fb_if.disp_bank, 0);

    // Request on the same clk as the edge waits one frame
    a0 = ack_cnt;
    tick(0, 492, 0, 1, 1);
    tick(0, 490, 0, 1, 0, 1'b1);
    chk("same_clk_ack", ack_cnt - a0, 0);
    chk("same_clk_bank", fb_if.disp_bank, 0);
    tick(0, 492, 0, 1, 1);
    tick(0, 490, 0, 1, 0);
    chk("same_clk_next_ack", ack_cnt - a0, 1);
    chk("same_clk_next_bank", fb_if.disp_bank, 1);

    // Reset while PENDING clears bank, pipeline and pending swap
    pulse_req();
    tick(5, 300, 1, 1, 1);
    tick(5, 300, 1, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bank", fb_if.disp_bank, 0);
    chk("mid_rst_hs_o", h_sync_o, 1);
    chk("mid_rst_vs_o", v_sync_o, 1);
    chk("mid_rst_de_o", DE_o, 0);
    chk("mid_rst_red", red, 0);
    reset = 1'b0;
    a0 = ack_cnt;
    tick(0, 489, 0, 1, 1);
    tick(0, 490, 0, 1, 0);
    chk("post_rst_ack", ack_cnt - a0, 0);
    chk("post_rst_bank", fb_if.disp_bank, 0);

    mem_word = 16'hF800;
    tick(5, 3, 1, 1, 1);
    tick(5, 3, 1, 1, 1);
    chk("post_rst_addr", last_addr, 322);
    chk("post_rst_red", red, 4'hF);
    chk("post_rst_de_o", DE_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
